// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel button conditioner.
// Defaults target a 38 MHz system clock with a 1 ms debounce tick.
package debounce_pkg;

    localparam int DEF_TICK_DIV   = 38000;
    localparam int DEF_DB_TICKS   = 20;
    localparam int DEF_LONG_TICKS = 1000;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter, accepted level,
// press/release pulses and a long-press hold counter driven by a shared tick.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DB_TICKS   = DEF_DB_TICKS,
    parameter int LONG_TICKS = DEF_LONG_TICKS,
    parameter int ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic n_reset,
    input  logic tick_i,
    input  logic btn_i,
    output logic db_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int SW = cnt_width(DB_TICKS);
    localparam int HW = cnt_width(LONG_TICKS);
    localparam logic [SW-1:0] DB_MAX   = SW'(DB_TICKS);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
    localparam logic          POL      = (ACTIVE_LOW != 0);

    logic          s1_q, s1_d, s2_q, s2_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          db_q, db_d;
    logic          press_q, press_d, release_q, release_d, long_q, long_d;
    logic          accept;

    always_comb begin
        s1_d = btn_i ^ POL;
        s2_d = s1_q;

        // Any disagreement between the sync stages restarts the stability count.
        stable_d = stable_q;
        if (s1_q != s2_q) begin
            stable_d = '0;
        end else if (tick_i && (stable_q < DB_MAX)) begin
            stable_d = stable_q + 1'b1;
        end

        accept    = (stable_q == DB_MAX) && (s2_q != db_q);
        db_d      = accept ? s2_q : db_q;
        press_d   = accept & s2_q;
        release_d = accept & ~s2_q;

        hold_d = hold_q;
        long_d = 1'b0;
        if (!db_q) begin
            hold_d = '0;
        end else if (tick_i && (hold_q < HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HOLD_MAX - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            stable_q  <= '0;
            hold_q    <= '0;
            db_q      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            hold_q    <= hold_d;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign db_o      = db_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/debounce_array.sv
// Multi-channel button conditioner: one shared tick prescaler feeding
// CHANNELS independent debounce channels.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int DB_TICKS   = DEF_DB_TICKS,
    parameter int LONG_TICKS = DEF_LONG_TICKS,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    logic tick;

    generate
        if (TICK_DIV == 1) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            localparam int PW = $clog2(TICK_DIV);
            localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

            logic [PW-1:0] ps_q, ps_d;

            always_comb begin
                ps_d = (ps_q == PS_MAX) ? '0 : ps_q + 1'b1;
            end

            always_ff @(posedge clk) begin
                if (!n_reset) begin
                    ps_q <= '0;
                end else begin
                    ps_q <= ps_d;
                end
            end

            // Decoded from the register so every channel sees the same phase.
            assign tick = (ps_q == PS_MAX);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            debounce_channel #(
                .DB_TICKS   (DB_TICKS),
                .LONG_TICKS (LONG_TICKS),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_ch (
                .clk       (clk),
                .n_reset   (n_reset),
                .tick_i    (tick),
                .btn_i     (btn_in[gi]),
                .db_o      (db_out[gi]),
                .press_o   (press_pulse[gi]),
                .release_o (release_pulse[gi]),
                .long_o    (long_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_array.sv
// Bench for debounce_array: an active-high and an active-low instance, checked every
// cycle against a tick-arithmetic model, plus literal latency/pulse-count checks.
module tb_debounce_array;

    localparam int CH = 4;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int LG = 5;
    localparam int NM = 2 * CH;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic [CH-1:0] btn_h = '0;
    logic [CH-1:0] btn_l = '0;
    logic [CH-1:0] db_h, pr_h, rl_h, lg_h;
    logic [CH-1:0] db_l, pr_l, rl_l, lg_l;

    always #5 clk = ~clk;

    debounce_array #(.CHANNELS(CH), .TICK_DIV(TD), .DB_TICKS(DB), .LONG_TICKS(LG), .ACTIVE_LOW(0)) dut_h (
        .clk(clk), .n_reset(n_reset), .btn_in(btn_h), .db_out(db_h),
        .press_pulse(pr_h), .release_pulse(rl_h), .long_pulse(lg_h)
    );

    debounce_array #(.CHANNELS(CH), .TICK_DIV(TD), .DB_TICKS(DB), .LONG_TICKS(LG), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .n_reset(n_reset), .btn_in(btn_l), .db_out(db_l),
        .press_pulse(pr_l), .release_pulse(rl_l), .long_pulse(lg_l)
    );

    int     n_checks = 0;
    int     n_fail = 0;
    longint cyc = 0;
    longint rst_e = 0;

    // Model state, indices 0..3 = dut_h channels, 4..7 = dut_l channels (pressed level).
    bit     m_db[NM], m_pr[NM], m_rl[NM], m_lg[NM];
    bit     pin1[NM], pin2[NM];
    longint lastchg[NM], rise_e[NM];
    int     press_seen[NM], release_seen[NM], long_seen[NM];

    // Tick edges are the edges e > reset edge with (e - reset edge) a multiple of TD.
    function automatic bit tick_at(input longint e);
        return (e > rst_e) && (((e - rst_e) % TD) == 0);
    endfunction

    function automatic longint ticks(input longint a, input longint b);
        if (b < a) return 0;
        return (b - rst_e) / TD - (a - 1 - rst_e) / TD;
    endfunction

    always @(posedge clk) begin
        bit     pin_now;
        longint cnt;
        cyc = cyc + 1;
        if (!n_reset) rst_e = cyc;
        for (int c = 0; c < NM; c++) begin
            pin_now = (c < CH) ? btn_h[c] : ~btn_l[c - CH];
            m_pr[c] = 1'b0;
            m_rl[c] = 1'b0;
            m_lg[c] = 1'b0;
            if (!n_reset) begin
                m_db[c]    = 1'b0;
                pin1[c]    = 1'b0;
                pin2[c]    = 1'b0;
                lastchg[c] = cyc - 1;
                rise_e[c]  = 0;
            end else begin
                cnt = ticks(lastchg[c] + 2, cyc - 1);
                if (cnt > DB) cnt = DB;
                if (m_db[c] && tick_at(cyc) && ticks(rise_e[c] + 1, cyc - 1) == LG - 1)
                    m_lg[c] = 1'b1;
                if (cnt == DB && pin2[c] != m_db[c]) begin
                    m_db[c] = pin2[c];
                    if (pin2[c]) begin
                        m_pr[c]   = 1'b1;
                        rise_e[c] = cyc;
                    end else begin
                        m_rl[c] = 1'b1;
                    end
                end
                pin2[c] = pin1[c];
                if (pin_now != pin1[c]) lastchg[c] = cyc;
                pin1[c] = pin_now;
            end
        end
    end

    // Per-cycle compare, sampled 2 time units after the active edge.
    always @(posedge clk) begin
        logic [3:0] act, exp_v;
        #2;
        for (int c = 0; c < NM; c++) begin
            if (c < CH) act = {db_h[c], pr_h[c], rl_h[c], lg_h[c]};
            else        act = {db_l[c-CH], pr_l[c-CH], rl_l[c-CH], lg_l[c-CH]};
            exp_v = {m_db[c], m_pr[c], m_rl[c], m_lg[c]};
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL model_cmp cyc%0d ch%0d: {db,press,release,long} got %b required %b",
                         cyc, c, act, exp_v);
            end
            if (act[2]) press_seen[c]++;
            if (act[1]) release_seen[c]++;
            if (act[0]) long_seen[c]++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp_v);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic bit db_bit(input int idx);
        return (idx < CH) ? db_h[idx] : db_l[idx - CH];
    endfunction

    task automatic wait_db(input int idx, input bit lvl, output longint at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (db_bit(idx) == lvl) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_db ch%0d: got no change required level %0d", idx, lvl);
        end
    endtask

    initial begin
        longint t0, d, t, acc, r_e;
        int     p0, l0, r0, k;

        // Reset with all pins active.
        btn_h = 4'hF;
        btn_l = 4'h0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outs", {db_h, pr_h, rl_h, lg_h, db_l, pr_l, rl_l, lg_l}, 0);
        end
        n_reset = 1'b1;
        btn_h = 4'h0;
        btn_l = 4'hF;
        @(negedge clk);
        chk("post_reset_outs", {db_h, pr_h, rl_h, lg_h, db_l, pr_l, rl_l, lg_l}, 0);
        repeat (20) @(negedge clk);

        // Clean press on channel 0.
        btn_h[0] = 1'b1;
        t0 = cyc;
        wait_db(0, 1'b1, d);
        chk_rng("press_latency", d - t0, 11, 15);
        chk("press_vec", pr_h, 4'b0001);
        @(negedge clk);
        chk("press_one_cycle", pr_h, 4'b0000);

        // Bouncing channel 1: toggles every 3 cycles, then settles high.
        p0 = press_seen[1];
        for (int b = 0; b < 10; b++) begin
            btn_h[1] = ~btn_h[1];
            repeat (3) @(negedge clk);
        end
        chk("bounce_no_pulse", press_seen[1] - p0, 0);
        chk("bounce_db_low", db_h[1], 0);
        btn_h[1] = 1'b1;
        t0 = cyc;
        wait_db(1, 1'b1, d);
        chk_rng("bounce_latency", d - t0, 11, 15);
        repeat (5) @(negedge clk);
        chk("bounce_one_press", press_seen[1] - p0, 1);

        // Long press on channel 2.
        btn_h[2] = 1'b1;
        wait_db(2, 1'b1, d);
        l0 = long_seen[2];
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lg_h[2]) begin
                t = cyc;
                break;
            end
        end
        chk_rng("long_delay", t - d, 17, 20);
        repeat (40) @(negedge clk);
        chk("long_once", long_seen[2] - l0, 1);
        btn_h[2] = 1'b0;
        wait_db(2, 1'b0, d);
        repeat (5) @(negedge clk);

        // Short press: pin released as soon as db_out rises.
        l0 = long_seen[2];
        r0 = release_seen[2];
        btn_h[2] = 1'b1;
        wait_db(2, 1'b1, d);
        btn_h[2] = 1'b0;
        wait_db(2, 0, d);
        repeat (5) @(negedge clk);
        chk("short_no_long", long_seen[2] - l0, 0);
        chk("short_one_release", release_seen[2] - r0, 1);

        // Active-low instance, channel 0.
        btn_l[0] = 1'b0;
        wait_db(CH, 1'b1, d);
        chk("al_press", pr_l[0], 1);
        btn_l[0] = 1'b1;
        wait_db(CH, 1'b0, d);
        chk("al_release", rl_l[0], 1);
        chk("al_release_no_press", pr_l[0], 0);

        // Clear channels 0/1 before the simultaneous test.
        btn_h[1:0] = 2'b00;
        wait_db(0, 1'b0, d);
        repeat (20) @(negedge clk);

        // Simultaneous press on channels 0 and 3.
        btn_h[0] = 1'b1;
        btn_h[3] = 1'b1;
        wait_db(0, 1'b1, d);
        chk("simul_press", pr_h, 4'b1001);
        chk("simul_db", db_h, 4'b1001);
        btn_h = 4'h0;
        wait_db(0, 1'b0, d);
        repeat (20) @(negedge clk);

        // Press 0 and 3 again, then reset two cycles before the predicted acceptance.
        btn_h[0] = 1'b1;
        btn_h[3] = 1'b1;
        t0 = cyc;
        t = t0 + 3;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            if (tick_at(t)) k++;
            if (k == DB) break;
            t++;
        end
        acc = t + 1;
        p0 = press_seen[0];
        while (cyc < acc - 3) @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        r_e = cyc;
        wait_db(0, 1'b1, d);
        chk("rerun_latency", d - r_e, 13);
        chk("rerun_press", pr_h, 4'b1001);
        @(negedge clk);
        chk("rerun_single_press", press_seen[0] - p0, 1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
